// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - IDLE/PLAYING/GAME_OVER round controller with saturating score and tick countdown.
// Optional GAME_FSM_SYNC_EN adds a 2-flop synchronizer in front of each event edge detector.
module game_fsm #(
  parameter int game_timer = 30
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       incrementClk,
  input  logic       startGame,
  input  logic       player_scored,
  input  logic       timer_expired,
  output logic       game_active,
  output logic [5:0] score
);

  localparam int RW = $clog2(game_timer + 1);
  localparam logic [RW-1:0] TIMER_INIT = RW'(game_timer);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAYING   = 2'b01,
    GAME_OVER = 2'b10
  } state_t;

  // Bit order: {expiry, score, tick, start}
  logic [3:0] raw;
  logic [3:0] ev_pulse;
  assign raw = {timer_expired, player_scored, incrementClk, startGame};

`ifdef GAME_FSM_SYNC_EN
  logic [3:0] sync1, sync2, sync3;
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end
  assign ev_pulse = sync2 & ~sync3;
`else
  logic [3:0] raw_q;
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) raw_q <= '0;
    else       raw_q <= raw;
  end
  assign ev_pulse = raw & ~raw_q;
`endif

  logic ev_start, ev_tick, ev_score, ev_expiry;
  assign {ev_expiry, ev_score, ev_tick, ev_start} = ev_pulse;

  state_t          state_q, state_next;
  logic [5:0]      score_q, score_next;
  logic [RW-1:0]   remaining_q, remaining_next;
  logic            active_q;

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      remaining_q <= TIMER_INIT;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_next;
      score_q     <= score_next;
      remaining_q <= remaining_next;
      active_q    <= (state_next == PLAYING);
    end
  end

  always_comb begin
    state_next     = state_q;
    score_next     = score_q;
    remaining_next = remaining_q;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (ev_start) begin
          state_next     = PLAYING;
          score_next     = '0;
          remaining_next = TIMER_INIT;
        end
      end
      PLAYING: begin
        // End conditions win and swallow a coincident point.
        if (ev_expiry || (ev_tick && remaining_q == RW'(1))) begin
          state_next = GAME_OVER;
          if (ev_tick) remaining_next = remaining_q - RW'(1);
        end else begin
          if (ev_tick) remaining_next = remaining_q - RW'(1);
          if (ev_score && score_q != 6'd63) score_next = score_q + 6'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign game_active = active_q;
  assign score       = score_q;

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - directed self-checking bench for game_fsm against a round-level model.
module tb_game_fsm;

  localparam int GT = 3;
`ifdef GAME_FSM_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, start, scored, expiry;
  logic       game_active;
  logic [5:0] score;

  int pass_cnt = 0;
  int total_cnt = 0;

  game_fsm #(.game_timer(GT)) dut (
    .clkIn(clk),
    .reset(reset),
    .incrementClk(tick),
    .startGame(start),
    .player_scored(scored),
    .timer_expired(expiry),
    .game_active(game_active),
    .score(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Round-level model: inputs seen at each edge, delayed by the conditioning latency.
  logic [3:0] hist [0:3];
  bit  m_playing;
  int  m_score, m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      m_playing = 0;
      m_score = 0;
      m_left = GT;
    end else begin
      logic [3:0] e;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {expiry, scored, tick, start};
      e = hist[LAT] & ~hist[LAT+1];
      if (!m_playing) begin
        if (e[0]) begin
          m_playing = 1;
          m_score = 0;
          m_left = GT;
        end
      end else if (e[3] || (e[1] && m_left == 1)) begin
        m_playing = 0;
      end else begin
        if (e[1]) m_left = m_left - 1;
        if (e[2] && m_score < 63) m_score = m_score + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_active", int'(game_active), int'(m_playing));
    check("model_score", int'(score), m_score);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: start = v;
      1: tick = v;
      2: scored = v;
      default: expiry = v;
    endcase
  endtask

  // One-cycle pulse, one low cycle, then wait out the conditioning latency.
  task automatic pulse(input int which);
    drive(which, 1'b1);
    step(1);
    drive(which, 1'b0);
    step(1 + LAT);
  endtask

  initial begin
    reset = 1'b1;
    {tick, start, scored, expiry} = '0;
    #20;
    check("reset_active", int'(game_active), 0);
    check("reset_score", int'(score), 0);
    step(1);
    reset = 1'b0;
    step(5);
    check("idle_active", int'(game_active), 0);
    check("idle_score", int'(score), 0);

    // Events before a start are ignored
    pulse(2);
    pulse(3);
    check("idle_ignore_score", int'(score), 0);

    pulse(0);
    check("start_active", int'(game_active), 1);
    check("start_score", int'(score), 0);

    pulse(2);
    step(8);
    check("score_one", int'(score), 1);
    pulse(2);
    check("score_two", int'(score), 2);
    check("still_active", int'(game_active), 1);

    // Held level counts once
    scored = 1'b1;
    step(6 + LAT);
    scored = 1'b0;
    step(1);
    check("held_counts_once", int'(score), 3);

    pulse(0);
    check("no_midround_restart", int'(score), 3);

    pulse(3);
    check("expiry_active", int'(game_active), 0);
    pulse(2);
    check("over_holds_score", int'(score), 3);

    pulse(0);
    check("restart_active", int'(game_active), 1);
    check("restart_score", int'(score), 0);

    pulse(2);
    check("pre_tick_score", int'(score), 1);

    // Three ticks at a 200 ns period; the last coincides with a point
    for (int t = 1; t <= GT; t++) begin
      tick = 1'b1;
      if (t == GT) scored = 1'b1;
      step(1);
      scored = 1'b0;
      step(9);
      tick = 1'b0;
      step(10);
      if (t < GT) check("tick_still_active", int'(game_active), 1);
    end
    check("tick_round_over", int'(game_active), 0);
    check("tick_point_discarded", int'(score), 1);

    pulse(0);
    check("second_restart", int'(game_active), 1);
    for (int i = 0; i < 70; i++) pulse(2);
    check("saturate", int'(score), 63);
    check("saturate_active", int'(game_active), 1);

    reset = 1'b1;
    #1;
    check("async_reset_active", int'(game_active), 0);
    check("async_reset_score", int'(score), 0);
    step(2);
    reset = 1'b0;
    step(3);
    check("post_reset_idle", int'(game_active), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
# game_fsm

Top-level game controller for the scoring game. Runs an IDLE → PLAYING → GAME_OVER state machine on the 100 MHz system clock, counts player points while a round is active, and ends the round on an external expiry request or after `game_timer` rising edges of the 1 Hz tick. Sits between the button/sensor front end and the score display.

## Interface
Parameters:
- `game_timer`, default 30: round length in rising edges of `incrementClk`. Legal range is 1–255.

Ports:
- `clkIn`, input, 1: the only clock, 100 MHz. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `incrementClk`, input, 1: 1 Hz tick. Treated as data, never as a clock. Its rising edges are detected in the `clkIn` domain.
- `startGame`, input, 1: start or restart request. Acts on its rising edge.
- `player_scored`, input, 1: point event. Acts on its rising edge.
- `timer_expired`, input, 1: external end-of-round request. Acts on its rising edge.
- `game_active`, output, 1: high only in PLAYING. Registered.
- `score`, output, 6: points in the current or last round. Registered.

## Operation
- Input conditioning: all four event inputs are processed identically, each to a one-`clkIn` rising-edge pulse. A level held high counts once. To retrigger, an input must return low for at least one `clkIn` edge.
- Internal countdown register `remaining`:
  - Width is the minimum needed to hold `game_timer`.
  - Reset value is `game_timer`.
- State IDLE (reset state):
  - `game_active` = 0, `score` = 0.
  - On a start edge: load `remaining` = `game_timer`, clear `score`, go to PLAYING.
  - Score, tick and expiry edges are ignored.
- State PLAYING:
  - `game_active` = 1.
  - Score edge: `score` increments by 1 and saturates at 63. It does not wrap.
  - Tick edge: `remaining` decrements. If `remaining` was 1, go to GAME_OVER.
  - Expiry edge: go to GAME_OVER.
  - Start edge: ignored. There is no mid-round restart.
- State GAME_OVER:
  - `game_active` = 0. `score` holds the final value.
  - On a start edge: clear `score`, reload `remaining`, go to PLAYING.
  - Score, tick and expiry edges are ignored.
- Simultaneous events in the same cycle while in PLAYING:
  - Any end condition (expiry edge, or the final tick) takes priority. The state goes to GAME_OVER and a coincident score edge is discarded.
  - A non-final tick together with a score edge: both take effect.
- Simultaneous events in IDLE or GAME_OVER: start wins and all others are ignored.
- Unused state encoding: recovers to IDLE on the next clock.

## Timing
- Reset values, applied asynchronously: state = IDLE, `game_active` = 0, `score` = 0, `remaining` = `game_timer`, all conditioning flops = 0.
- Latency is measured from rising edge N, the first `clkIn` edge that samples an event input high (see Configuration for the conditioning path):
  - With `GAME_FSM_SYNC_EN`: the resulting output change is visible after edge N+2.
  - Without it: the change is visible after edge N.
- Minimum event pulse width is one `clkIn` period covering a rising edge.
- A round lasts exactly `game_timer` detected tick edges, plus the conditioning latency.
- Reset asserted mid-round aborts immediately: `game_active` drops and `score` clears without waiting for a clock edge.

## Configuration
- Macro: `GAME_FSM_SYNC_EN`.
- Defined: each event input passes through a 2-flop synchronizer. Its rising edge is detected by comparing the synchronizer output against a further delayed copy. This path is safe for asynchronous buttons and adds 2 cycles of latency.
- Undefined: the edge is the raw input ANDed with the inverse of its 1-cycle registered copy. There is no metastability protection. This mode is for synchronous stimulus only.
- FSM behaviour is identical in both builds. Only the latency differs.

## Test plan
- Hold `reset` = 1 for 20 ns, then release; drive no events. → `game_active` = 0 and `score` = 0 throughout.
- Release reset, then pulse `startGame` for 10 ns. → `game_active` = 1 at the configured latency; `score` = 0.
- While PLAYING, pulse `player_scored` twice, 100 ns apart, each 10 ns wide. → `score` goes 1 then 2; `game_active` stays 1.
- Pulse `timer_expired` for 10 ns, then pulse `player_scored`. → `game_active` = 0; `score` holds 2. Then pulse `startGame`. → `game_active` = 1 and `score` = 0.
- Build with `game_timer` = 3 and give `incrementClk` a 200 ns period. → `game_active` falls after the 3rd tick edge. Also assert `player_scored` in the same cycle as the 3rd tick edge. → that point is discarded.
- Give 70 score pulses. → `score` saturates at 63. Then assert `reset` mid-round. → immediate `game_active` = 0 and `score` = 0.
